pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 17 +
 rtl/pipe_stage_skid_if.sv | 33 +++
 rtl/pipe_stall_counter.sv | 27 ++
 rtl/pipe_stage_skid.sv | 135 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// rtl/pipe_stage_skid_pkg.sv - shared pipeline-stage constants and state encoding
// Purpose: default payload widths and the valid-state encoding used by every
//          skid-buffered pipeline stage.
// Ports:   none (package)
package pipe_stage_skid_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 8;

   // Bit 0 = main register valid, bit 1 = skid register valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake bundle of a pipeline stage
// Purpose: groups the valid/ready/payload signals on both sides of a stage.
// Ports:   in_valid_i/in_ready_o/in_data_i/in_ctrl_i    upstream side
//          out_valid_o/out_ready_i/out_data_o/out_ctrl_o downstream side
//          modport slave  = the stage itself
//          modport master = the environment driving and consuming the stage
interface pipe_stage_skid_if
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
);

   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_i;
   logic [CTRL_W-1:0] in_ctrl_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic [CTRL_W-1:0] out_ctrl_o;

   modport slave (
      input  in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_ctrl_o
   );

   modport master (
      output in_valid_i, in_data_i, in_ctrl_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o
   );

endinterface

// File: rtl/pipe_stall_counter.sv
// rtl/pipe_stall_counter.sv - saturating stall-cycle counter
// Purpose: counts cycles flagged by inc, sticking at the all-ones value.
// Ports:   clk_i  clock
//          rst_n  asynchronous active-low reset, clears the count
//          inc    count this cycle
//          cnt    current count
module pipe_stall_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_INC;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - registered pipeline stage with skid buffer and flush
// Purpose: full-throughput pipeline register whose upstream ready comes only
//          from a flop; a one-entry skid register absorbs the in-flight word
//          when downstream stalls. Flush squashes both entries.
// Ports:   clk_i        clock
//          rst_n        asynchronous active-low reset
//          bus          handshake bundle (slave side)
//          flush_i      synchronous squash, highest priority
//          stall_cnt_o  saturating count of cycles held by downstream
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n,
   pipe_stage_skid_if.slave  bus,
   input  logic              flush_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   skid_state_e       state_q;
   skid_state_e       state_d;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic              main_valid;
   logic              skid_valid;
   logic              in_xfer;
   logic              out_xfer;
   logic              main_from_in;
   logic              main_from_skid;
   logic              skid_from_in;

   // Both valids decode straight from the state flop, so in_ready_o has no
   // combinational dependency on out_ready_i.
   assign main_valid = state_q[0];
   assign skid_valid = state_q[1];
   assign in_xfer    = bus.in_valid_i && !skid_valid;
   assign out_xfer   = main_valid && bus.out_ready_i;

   assign bus.in_ready_o  = !skid_valid;
   assign bus.out_valid_o = main_valid;
   assign bus.out_data_o  = main_data_q;
   assign bus.out_ctrl_o  = main_ctrl_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d      = ST_ONE;
                  main_from_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_from_in = 1'b1;
               end else if (in_xfer) begin
                  state_d      = ST_FULL;
                  skid_from_in = 1'b1;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // Upstream is blocked here, so only a drain can happen.
               if (out_xfer) begin
                  state_d        = ST_ONE;
                  main_from_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Data is held across bubbles and flushes to avoid needless toggling;
   // control is forced to zero whenever the main entry goes invalid.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         main_data_q <= '0;
         main_ctrl_q <= '0;
      end else if (main_from_in) begin
         main_data_q <= bus.in_data_i;
         main_ctrl_q <= bus.in_ctrl_i;
      end else if (main_from_skid) begin
         main_data_q <= skid_data_q;
         main_ctrl_q <= skid_ctrl_q;
      end else if (state_d == ST_EMPTY) begin
         main_ctrl_q <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else if (flush_i) begin
         skid_ctrl_q <= '0;
      end else if (skid_from_in) begin
         skid_data_q <= bus.in_data_i;
         skid_ctrl_q <= bus.in_ctrl_i;
      end
   end

   pipe_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_counter (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .inc   (main_valid && !bus.out_ready_i),
      .cnt   (stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic [CNT_W-1:0] stall_cnt;
   int               n_cmp = 0;
   int               n_bad = 0;
   logic [39:0]      sb_q[$];
   logic [39:0]      exp_word;

   always #5 clk = ~clk;

   pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(8)) bus ();

   pipe_stage_skid #(
      .DATA_W (32),
      .CTRL_W (8),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .flush_i     (flush),
      .stall_cnt_o (stall_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
      bus.in_valid_i = v;
      bus.in_data_i  = d;
      bus.in_ctrl_i  = c;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      drive(1'b0, 32'h0, 8'h0);
      bus.out_ready_i = 1'b0;
      #2;
      check("rst_valid", bus.out_valid_o, 0);
      check("rst_data",  bus.out_data_o,  0);
      check("rst_ctrl",  bus.out_ctrl_o,  0);
      check("rst_ready", bus.in_ready_o,  1);
      check("rst_stall", stall_cnt,       0);
      tick();
      rst_n = 1'b1;

      // Streaming: first word accepted on the first edge after reset release.
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h10 + i, 8'(i + 1));
         tick();
         check("stream_valid", bus.out_valid_o, 1);
         check("stream_data",  bus.out_data_o,  32'h10 + i);
         check("stream_ctrl",  bus.out_ctrl_o,  i + 1);
         check("stream_ready", bus.in_ready_o,  1);
      end
      drive(1'b0, 32'h0, 8'h0);
      tick();
      check("stream_bubble_valid", bus.out_valid_o, 0);
      check("stream_bubble_ctrl",  bus.out_ctrl_o,  0);
      check("stream_bubble_hold",  bus.out_data_o,  32'h17);
      check("stream_stall",        stall_cnt,       0);

      // Backpressure into FULL, then drain in order.
      pulse_reset();
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'hA, 8'h0A);
      tick();
      check("bp_a_valid", bus.out_valid_o, 1);
      check("bp_a_data",  bus.out_data_o,  32'hA);
      check("bp_a_ready", bus.in_ready_o,  1);
      check("bp_a_stall", stall_cnt,       0);
      drive(1'b1, 32'hB, 8'h0B);
      tick();
      check("bp_full_data",  bus.out_data_o, 32'hA);
      check("bp_full_ready", bus.in_ready_o, 0);
      check("bp_full_stall", stall_cnt,      1);
      drive(1'b1, 32'hEE, 8'hEE);
      tick();
      check("bp_hold_data",  bus.out_data_o, 32'hA);
      check("bp_hold_ready", bus.in_ready_o, 0);
      check("bp_hold_stall", stall_cnt,      2);
      bus.out_ready_i = 1'b1;
      tick();
      drive(1'b0, 32'h0, 8'h0);
      check("bp_b_valid", bus.out_valid_o, 1);
      check("bp_b_data",  bus.out_data_o,  32'hB);
      check("bp_b_ctrl",  bus.out_ctrl_o,  8'h0B);
      check("bp_b_ready", bus.in_ready_o,  1);
      check("bp_b_stall", stall_cnt,       2);
      tick();
      check("bp_empty_valid", bus.out_valid_o, 0);
      check("bp_empty_ctrl",  bus.out_ctrl_o,  0);
      check("bp_empty_stall", stall_cnt,       2);

      // Flush while FULL with an offered input.
      pulse_reset();
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h1, 8'h11);
      tick();
      drive(1'b1, 32'h2, 8'h22);
      tick();
      check("fl_full_ready", bus.in_ready_o, 0);
      flush = 1'b1;
      drive(1'b1, 32'hC, 8'hFF);
      tick();
      check("fl_valid", bus.out_valid_o, 0);
      check("fl_ctrl",  bus.out_ctrl_o,  0);
      check("fl_ready", bus.in_ready_o,  1);
      check("fl_hold",  bus.out_data_o,  32'h1);
      check("fl_stall", stall_cnt,       2);
      flush = 1'b0;
      drive(1'b0, 32'h0, 8'h0);
      bus.out_ready_i = 1'b1;
      tick();
      check("fl_after_valid", bus.out_valid_o, 0);

      // Flush in ONE while an input transfer actually happens: it is dropped.
      drive(1'b1, 32'h3, 8'h33);
      tick();
      check("fl1_data", bus.out_data_o, 32'h3);
      flush = 1'b1;
      drive(1'b1, 32'hC, 8'hFF);
      tick();
      check("fl1_valid", bus.out_valid_o, 0);
      check("fl1_ctrl",  bus.out_ctrl_o,  0);
      flush = 1'b0;
      drive(1'b0, 32'h0, 8'h0);
      tick();
      check("fl1_after_valid", bus.out_valid_o, 0);

      // Stall counter saturation at 2^CNT_W-1.
      pulse_reset();
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h77, 8'h07);
      tick();
      drive(1'b0, 32'h0, 8'h0);
      repeat (10) tick();
      check("sat_mid", stall_cnt, 10);
      repeat (10) tick();
      check("sat_end",  stall_cnt,      15);
      check("sat_data", bus.out_data_o, 32'h77);

      // Asynchronous reset between edges while FULL.
      pulse_reset();
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h21, 8'h21);
      tick();
      drive(1'b1, 32'h22, 8'h22);
      tick();
      drive(1'b0, 32'h0, 8'h0);
      check("ar_full_ready", bus.in_ready_o, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", bus.out_valid_o, 0);
      check("ar_data",  bus.out_data_o,  0);
      check("ar_ctrl",  bus.out_ctrl_o,  0);
      check("ar_ready", bus.in_ready_o,  1);
      check("ar_stall", stall_cnt,       0);
      #1;
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      drive(1'b1, 32'h55, 8'h05);
      tick();
      drive(1'b0, 32'h0, 8'h0);
      check("ar_55_valid", bus.out_valid_o, 1);
      check("ar_55_data",  bus.out_data_o,  32'h55);
      tick();
      check("ar_55_drain", bus.out_valid_o, 0);

      // Random valid/ready/flush against a FIFO scoreboard.
      pulse_reset();
      sb_q.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         drive($urandom_range(0, 9) < 6, $urandom, 8'($urandom_range(1, 255)));
         bus.out_ready_i = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 31) == 0);
         #1;
         check("rnd_valid", bus.out_valid_o, sb_q.size() != 0);
         check("rnd_ready", bus.in_ready_o,  sb_q.size() < 2);
         if (sb_q.size() == 0) begin
            check("rnd_bubble_ctrl", bus.out_ctrl_o, 0);
         end
         if (bus.out_valid_o && bus.out_ready_i && sb_q.size() != 0) begin
            exp_word = sb_q.pop_front();
            check("rnd_data", {bus.out_ctrl_o, bus.out_data_o}, exp_word);
         end
         if (flush) begin
            sb_q.delete();
         end else if (bus.in_valid_i && bus.in_ready_o) begin
            sb_q.push_back({bus.in_ctrl_i, bus.in_data_i});
         end
         tick();
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
